hazard_tracker: RTL and testbench



---
 rtl/hazard_tracker_if.sv | 36 +++
 rtl/hazard_tracker.sv | 138 +++++++++++++
 tb/tb_hazard_tracker.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_tracker_if.sv
// Decode-stage hazard query bundle: the instruction currently in decode and the
// stall/forwarding answer returned for it.
interface hazard_tracker_if #(
    parameter int T_SIZE = 3,
    parameter int SEL_W  = 2
);
    logic                     d_valid;
    logic [4:0]               d_rs;
    logic [4:0]               d_rt;
    logic signed [T_SIZE-1:0] d_tuse_rs;
    logic signed [T_SIZE-1:0] d_tuse_rt;
    logic                     d_wr_en;
    logic [4:0]               d_dst;
    logic [T_SIZE-1:0]        d_tnew;
    logic                     d_md_start;
    logic                     d_md_div;
    logic                     d_md_use;
    logic                     stall;
    logic [SEL_W-1:0]         fwd_rs_sel;
    logic [SEL_W-1:0]         fwd_rt_sel;
    logic                     fwd_rs_rdy;
    logic                     fwd_rt_rdy;
    logic                     md_busy;

    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wr_en, d_dst, d_tnew,
               d_md_start, d_md_div, d_md_use,
        input  stall, fwd_rs_sel, fwd_rt_sel, fwd_rs_rdy, fwd_rt_rdy, md_busy
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wr_en, d_dst, d_tnew,
               d_md_start, d_md_div, d_md_use,
        output stall, fwd_rs_sel, fwd_rt_sel, fwd_rs_rdy, fwd_rt_rdy, md_busy
    );
endinterface

// File: rtl/hazard_tracker.sv
// Stall / forwarding tracker beside decode. Keeps one record per downstream
// stage of in-flight GPR writes (dst, remaining Tnew) and checks the decode
// operands' Tuse against it. Slot 0 = E, slot STAGES-1 = last writeback stage.
// Optional multiply/divide busy tracking is enabled by defining MDU_BUSY_EN.
module hazard_tracker #(
    parameter int STAGES      = 3,
    parameter int T_SIZE      = 3,
    parameter int SEL_W       = $clog2(STAGES + 1),
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic            clk,
    input logic            reset_n,
    hazard_tracker_if.slave hz
);

    logic [STAGES-1:0]             vld_q, vld_d;
    logic [STAGES-1:0][4:0]        dst_q, dst_d;
    logic [STAGES-1:0][T_SIZE-1:0] tnew_q, tnew_d;

    logic             gpr_stall;
    logic             stall;
    logic             rs_stall, rt_stall;
    logic             rs_rdy, rt_rdy;
    logic [SEL_W-1:0] rs_sel, rt_sel;

    // Youngest match wins the select; any match whose result is not yet due stalls.
    // A negative Tuse (sign bit set) means the operand is not read at all.
    function automatic logic [SEL_W+1:0] lookup(
        input logic [4:0]                    src,
        input logic [T_SIZE-1:0]             tuse,
        input logic [STAGES-1:0]             vld,
        input logic [STAGES-1:0][4:0]        dst,
        input logic [STAGES-1:0][T_SIZE-1:0] tnew
    );
        logic             st;
        logic             rdy;
        logic [SEL_W-1:0] sel;
        st  = 1'b0;
        rdy = 1'b1;
        sel = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (vld[k] && (dst[k] == src) && !tuse[T_SIZE-1]) begin
                if (tnew[k] > tuse) st = 1'b1;
                sel = SEL_W'(k + 1);
                rdy = (tnew[k] == '0);
            end
        end
        return {st, rdy, sel};
    endfunction

    // Operand lookups against the registered slot record.
    always_comb begin
        {rs_stall, rs_rdy, rs_sel} = lookup(hz.d_rs, hz.d_tuse_rs, vld_q, dst_q, tnew_q);
        {rt_stall, rt_rdy, rt_sel} = lookup(hz.d_rt, hz.d_tuse_rt, vld_q, dst_q, tnew_q);
        gpr_stall = hz.d_valid & (rs_stall | rt_stall);
    end

`ifdef MDU_BUSY_EN
    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW     = $clog2(MD_MAX + 1);

    logic [CW-1:0] md_cnt_q, md_cnt_d;
    logic          md_s0_q, md_s0_d;
    logic          md_busy;
    logic          md_go;

    // MDU occupancy: the counter loads on an accepted start and runs down to 0.
    always_comb begin
        md_busy  = (md_cnt_q != '0) | md_s0_q;
        stall    = gpr_stall | (hz.d_valid & hz.d_md_use & md_busy);
        md_go    = hz.d_valid & hz.d_md_start & ~stall;
        md_s0_d  = md_go;
        md_cnt_d = (md_cnt_q != '0) ? md_cnt_q - CW'(1) : '0;
        if (md_go) md_cnt_d = hz.d_md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end

    // MDU counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt_q <= '0;
            md_s0_q  <= 1'b0;
        end else begin
            md_cnt_q <= md_cnt_d;
            md_s0_q  <= md_s0_d;
        end
    end
`else
    logic md_busy;
    logic unused_md;

    // Without MDU tracking the stall is purely the GPR decision.
    always_comb begin
        md_busy   = 1'b0;
        stall     = gpr_stall;
        unused_md = hz.d_md_start ^ hz.d_md_div ^ hz.d_md_use;
    end
`endif

    // Slot shift: new write enters slot 0, older entries age with saturating Tnew.
    always_comb begin
        vld_d     = '0;
        dst_d     = '0;
        tnew_d    = '0;
        vld_d[0]  = hz.d_valid & ~stall & hz.d_wr_en & (hz.d_dst != 5'd0);
        dst_d[0]  = hz.d_dst;
        tnew_d[0] = hz.d_tnew;
        for (int i = 1; i < STAGES; i++) begin
            vld_d[i]  = vld_q[i-1];
            dst_d[i]  = dst_q[i-1];
            tnew_d[i] = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - T_SIZE'(1);
        end
    end

    // Slot record register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= '0;
            dst_q  <= '0;
            tnew_q <= '0;
        end else begin
            vld_q  <= vld_d;
            dst_q  <= dst_d;
            tnew_q <= tnew_d;
        end
    end

    // Drive the answer back onto the bundle.
    always_comb begin
        hz.stall      = stall;
        hz.fwd_rs_sel = rs_sel;
        hz.fwd_rt_sel = rt_sel;
        hz.fwd_rs_rdy = rs_rdy;
        hz.fwd_rt_rdy = rt_rdy;
        hz.md_busy    = md_busy;
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Scoreboard bench for hazard_tracker: a 3-stage instance (main checks) and a
// 5-stage instance (deep forwarding walk). Expectations are queued by the
// driver each cycle and compared by an independent negedge monitor.
module tb_hazard_tracker;

    logic clk;
    logic reset_n;

`ifdef MDU_BUSY_EN
    localparam int MDU = 1;
`else
    localparam int MDU = 0;
`endif

    hazard_tracker_if #(.T_SIZE(3), .SEL_W(2)) ifa ();
    hazard_tracker_if #(.T_SIZE(3), .SEL_W(3)) ifb ();

    hazard_tracker #(.STAGES(3), .T_SIZE(3)) u_a (.clk(clk), .reset_n(reset_n), .hz(ifa));
    hazard_tracker #(.STAGES(5), .T_SIZE(3)) u_b (.clk(clk), .reset_n(reset_n), .hz(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -1 in any field means "not checked this cycle"
    typedef struct {
        string n;
        int st, rss, rsr, rts, rtr, bz, bs, br;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(string n, int st, int rss, int rsr, int rts, int rtr,
                                int bz, int bs, int br);
        exp_t e;
        e.n = n; e.st = st; e.rss = rss; e.rsr = rsr; e.rts = rts; e.rtr = rtr;
        e.bz = bz; e.bs = bs; e.br = br;
        return e;
    endfunction

    task automatic chk(string n, string f, int act, int exp);
        if (exp < 0) return;
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s.%s actual=%0d required=%0d", n, f, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.n, "stall",      int'(ifa.stall),      e.st);
            chk(e.n, "rs_sel",     int'(ifa.fwd_rs_sel), e.rss);
            chk(e.n, "rs_rdy",     int'(ifa.fwd_rs_rdy), e.rsr);
            chk(e.n, "rt_sel",     int'(ifa.fwd_rt_sel), e.rts);
            chk(e.n, "rt_rdy",     int'(ifa.fwd_rt_rdy), e.rtr);
            chk(e.n, "md_busy",    int'(ifa.md_busy),    e.bz);
            chk(e.n, "b_rs_sel",   int'(ifb.fwd_rs_sel), e.bs);
            chk(e.n, "b_rs_rdy",   int'(ifb.fwd_rs_rdy), e.br);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_in(bit v, int rs, int trs, int rt, int trt, bit wr, int dst, int tnew,
                        bit ms, bit mu);
        ifa.d_valid    = v;
        ifa.d_rs       = 5'(rs);
        ifa.d_tuse_rs  = 3'(trs);
        ifa.d_rt       = 5'(rt);
        ifa.d_tuse_rt  = 3'(trt);
        ifa.d_wr_en    = wr;
        ifa.d_dst      = 5'(dst);
        ifa.d_tnew     = 3'(tnew);
        ifa.d_md_start = ms;
        ifa.d_md_div   = 1'b0;
        ifa.d_md_use   = mu;
    endtask

    task automatic a_idle();
        a_in(0, 0, -1, 0, -1, 0, 0, 0, 0, 0);
    endtask

    task automatic a_wr(int dst, int tnew);
        a_in(1, 0, -1, 0, -1, 1, dst, tnew, 0, 0);
    endtask

    task automatic b_in(bit v, int rs, int trs, bit wr, int dst, int tnew);
        ifb.d_valid    = v;
        ifb.d_rs       = 5'(rs);
        ifb.d_tuse_rs  = 3'(trs);
        ifb.d_rt       = 5'd0;
        ifb.d_tuse_rt  = -3'sd1;
        ifb.d_wr_en    = wr;
        ifb.d_dst      = 5'(dst);
        ifb.d_tnew     = 3'(tnew);
        ifb.d_md_start = 1'b0;
        ifb.d_md_div   = 1'b0;
        ifb.d_md_use   = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        // conflicting decode traffic while reset is held
        a_in(1, 8, 0, 8, 0, 1, 8, 2, 1, 1);
        b_in(1, 7, 0, 1, 7, 2);
        tick(); q.push_back(mk("rst0", 0, 0, 1, 0, 1, 0, 0, 1));
        tick(); q.push_back(mk("rst1", 0, 0, 1, 0, 1, 0, 0, 1));
        tick(); reset_n = 1'b1; a_idle(); b_in(0, 0, -1, 0, 0, 0);
        q.push_back(mk("rel", 0, 0, 1, 0, 1, 0, 0, 1));

        // first write after release, then a tuse=1 read of it
        tick(); a_wr(8, 1);                          q.push_back(mk("w8", 0, -1, -1, -1, -1, -1, -1, -1));
        tick(); a_in(1, 8, 1, 0, -1, 0, 0, 0, 0, 0); q.push_back(mk("rd8a", 0, 1, 0, 0, 1, -1, -1, -1));
        tick(); a_in(1, 8, 1, 8, 1, 0, 0, 0, 0, 0);  q.push_back(mk("rd8b", 0, 2, 1, 2, 1, -1, -1, -1));

        // load-use: one stall, then forwarded from slot 1
        tick(); a_wr(8, 2);                          q.push_back(mk("lw", 0, -1, -1, -1, -1, -1, -1, -1));
        tick(); a_in(1, 8, 1, 0, -1, 1, 9, 1, 0, 0); q.push_back(mk("lu0", 1, 1, 0, -1, -1, -1, -1, -1));
        tick(); a_in(1, 8, 1, 0, -1, 1, 9, 1, 0, 0); q.push_back(mk("lu1", 0, 2, -1, -1, -1, -1, -1, -1));
        tick(); a_idle();                            q.push_back(mk("lu2", 0, -1, -1, -1, -1, -1, -1, -1));

        // beq after add
        tick(); a_wr(10, 1);                          q.push_back(mk("add", 0, -1, -1, -1, -1, -1, -1, -1));
        tick(); a_in(1, 10, 0, 0, -1, 0, 0, 0, 0, 0); q.push_back(mk("bqa0", 1, 1, 0, -1, -1, -1, -1, -1));
        tick(); a_in(1, 10, 0, 0, -1, 0, 0, 0, 0, 0); q.push_back(mk("bqa1", 0, 2, 1, -1, -1, -1, -1, -1));
        tick(); a_idle();                             q.push_back(mk("idle", 0, -1, -1, -1, -1, -1, -1, -1));

        // beq after lw: two stalls
        tick(); a_wr(11, 2);                          q.push_back(mk("lw11", 0, -1, -1, -1, -1, -1, -1, -1));
        tick(); a_in(1, 11, 0, 0, -1, 0, 0, 0, 0, 0); q.push_back(mk("bql0", 1, 1, 0, -1, -1, -1, -1, -1));
        tick(); a_in(1, 11, 0, 0, -1, 0, 0, 0, 0, 0); q.push_back(mk("bql1", 1, 2, 0, -1, -1, -1, -1, -1));
        tick(); a_in(1, 11, 0, 0, -1, 0, 0, 0, 0, 0); q.push_back(mk("bql2", 0, 3, 1, -1, -1, -1, -1, -1));
        tick(); a_idle();                             q.push_back(mk("idle", -1, -1, -1, -1, -1, -1, -1, -1));

        // two writes to $9 in slots 0 and 2: youngest wins even if not ready
        tick(); a_wr(9, 2);                          q.push_back(mk("w9a", -1, -1, -1, -1, -1, -1, -1, -1));
        tick(); a_idle();                            q.push_back(mk("idle", -1, -1, -1, -1, -1, -1, -1, -1));
        tick(); a_wr(9, 1);                          q.push_back(mk("w9b", -1, -1, -1, -1, -1, -1, -1, -1));
        tick(); a_in(1, 0, -1, 9, 2, 0, 0, 0, 0, 0); q.push_back(mk("rd9", 0, 0, 1, 1, 0, -1, -1, -1));

        // older match still late while younger is ready: stall, select younger
        tick(); a_wr(12, 5);                          q.push_back(mk("w12a", -1, -1, -1, -1, -1, -1, -1, -1));
        tick(); a_idle();                             q.push_back(mk("idle", -1, -1, -1, -1, -1, -1, -1, -1));
        tick(); a_wr(12, 0);                          q.push_back(mk("w12b", -1, -1, -1, -1, -1, -1, -1, -1));
        tick(); a_in(1, 12, 0, 0, -1, 0, 0, 0, 0, 0); q.push_back(mk("rd12", 1, 1, 1, -1, -1, -1, -1, -1));

        // $0 is never tracked
        tick(); a_wr(0, 2);                          q.push_back(mk("w0", -1, -1, -1, -1, -1, -1, -1, -1));
        tick(); a_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);  q.push_back(mk("rd0", 0, 0, 1, 0, 1, -1, -1, -1));

        // mid-stream reset drops tracked writes
        tick(); a_wr(13, 2);                         q.push_back(mk("w13", -1, -1, -1, -1, -1, -1, -1, -1));
        tick(); reset_n = 1'b0; a_in(1, 13, 0, 0, -1, 0, 0, 0, 0, 0);
        q.push_back(mk("mrst", 0, 0, 1, -1, -1, 0, -1, -1));
        tick(); reset_n = 1'b1; a_in(1, 13, 0, 0, -1, 0, 0, 0, 0, 0);
        q.push_back(mk("mrel", 0, 0, 1, -1, -1, 0, -1, -1));

        // 5-stage instance: tnew=4 walks sel 1..5, ready at slot 4
        tick(); a_idle(); b_in(1, 0, -1, 1, 7, 4);
        q.push_back(mk("bw7", -1, -1, -1, -1, -1, -1, -1, -1));
        for (int k = 1; k <= 5; k++) begin
            tick(); b_in(1, 7, 3, 0, 0, 0);
            q.push_back(mk($sformatf("bwalk%0d", k), -1, -1, -1, -1, -1, -1, k, (k == 5) ? 1 : 0));
        end
        tick(); b_in(0, 0, -1, 0, 0, 0);
        q.push_back(mk("bidle", -1, -1, -1, -1, -1, -1, 0, 1));

        // MDU: mult then mfhi held in decode
        tick(); a_in(1, 0, -1, 0, -1, 0, 0, 0, 1, 1); q.push_back(mk("mult", 0, -1, -1, -1, -1, 0, -1, -1));
        for (int k = 1; k <= 5; k++) begin
            tick(); a_in(1, 0, -1, 0, -1, 0, 0, 0, 0, 1);
            q.push_back(mk($sformatf("mfhi%0d", k), MDU, -1, -1, -1, -1, MDU, -1, -1));
        end
        tick(); a_in(1, 0, -1, 0, -1, 0, 0, 0, 0, 1);
        q.push_back(mk("mfhi6", 0, -1, -1, -1, -1, 0, -1, -1));
        tick(); a_idle(); q.push_back(mk("end", 0, 0, 1, 0, 1, 0, -1, -1));

        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
